ext_slow_memory: RTL and testbench
==================================

// Module: ext_slow_memory
// PURPOSE
//  OBI slave memory occupying the SLOW_MEMORY window of the external crossbar
//  (slave idx 0, base EXT_SLAVE_START_ADDRESS, 0x200 bytes).
//  Inserts programmable grant and response latency so the bench can exercise
//  bus stalls and back-pressure seen by CPU/DMA masters through the external xbar.
//  Consumes the xbar's slave-0 request port; returns responses to the same port.
//  One transaction in flight at a time.
// PARAMETERS
//  NUM_WORDS       128  32-bit words stored (0x200 bytes); power of two, >=2
//  GNT_LATENCY     2    cycles from first req seen in IDLE to gnt_o; >=1
//  RVALID_LATENCY  3    cycles from gnt cycle to rvalid_o; >=1
// PORTS
//  clk_i      in   1   clock
//  rst_ni     in   1   asynchronous active-low reset
//  req_i      in   1   OBI request valid
//  gnt_o      out  1   OBI grant, 1-cycle pulse
//  addr_i     in   32  byte address; word idx = addr_i[$clog2(NUM_WORDS)+1:2], others ignored
//  we_i       in   1   1 = write, 0 = read
//  be_i       in   4   byte enables (writes only)
//  wdata_i    in   32  write data
//  rvalid_o   out  1   response valid, 1-cycle pulse
//  rdata_o    out  32  read data; 0 for write responses
// BEHAVIOUR
//  Reset: gnt_o=0, rvalid_o=0, rdata_o=0, FSM=IDLE, counter=0.
//   Memory array not reset.
//  FSM states: IDLE, GNT_WAIT, RESP_WAIT.
//  - IDLE: req_i=1 -> load cnt=GNT_LATENCY-1.
//    If GNT_LATENCY==1: gnt_o=1 next cycle (GNT_WAIT with cnt=0).
//    Else: GNT_WAIT.
//  - GNT_WAIT: cnt!=0 -> decrement.
//    cnt==0 & req_i=1 -> gnt_o=1 this cycle; sample addr/we/be/wdata.
//      Write: commit bytes with be_i=1 in this cycle.
//      Read: capture mem[idx] into response register.
//      Then load cnt=RVALID_LATENCY-1 -> RESP_WAIT.
//    req_i drops before gnt -> back to IDLE; no access (master protocol violation, tolerated).
//  - RESP_WAIT: cnt!=0 -> decrement. cnt==0 -> rvalid_o=1 for one cycle.
//    rdata_o = captured word for reads, 32'h0 for writes.
//    In the rvalid cycle, req_i=1 -> load GNT_LATENCY-1 -> GNT_WAIT; else -> IDLE.
//  gnt_o/rvalid_o are registered (driven from state), never combinational from req_i.
//  Latency: gnt GNT_LATENCY cycles after req rises; rvalid RVALID_LATENCY cycles after gnt.
//  Minimum back-to-back period: GNT_LATENCY+RVALID_LATENCY cycles.
//  No gnt while a response is pending; masters must hold req_i and payload stable until gnt.
//  rdata_o holds its last value between pulses; sampled only when rvalid_o=1.
//  Read-after-write to the same word returns new data (write committed at gnt, before any later read).
//  be_i=4'b0000 write: no bytes change; response still issued.
//  Address wrap: addr bits above the index field are ignored.
//   E.g. base+0x200 aliases word 0 (xbar decode prevents this in normal use).
//  Reset mid-transaction: in-flight access is abandoned and no rvalid is issued.
//   A write that was already granted stays committed.
// TESTING
//  1. Reset release, no req -> gnt_o=0, rvalid_o=0, rdata_o=0 for 20 cycles.
//  2. Write 0xDEADBEEF be=4'hF @base+0x10, then read @base+0x10 -> rdata=0xDEADBEEF;
//     gnt 2 cycles after req, rvalid 3 cycles after gnt.
//  3. Write 0x11223344 be=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
//  4. req held high for 4 back-to-back reads -> exactly one gnt per 5 cycles; no overlap of gnt and pending response.
//  5. req raised 1 cycle, dropped before gnt -> no gnt, no rvalid, memory unchanged, FSM back to IDLE.
//  6. rst_ni low in RESP_WAIT of a read -> outputs 0 immediately; no rvalid after release;
//     next read completes normally. Repeat with GNT_LATENCY=1, RVALID_LATENCY=1.

Source files
------------

// File: rtl/ext_slow_memory.sv
// OBI slave memory for the external crossbar SLOW_MEMORY window with programmable
// grant and response latency; a single transaction is in flight at a time.
module ext_slow_memory #(
  parameter int unsigned NUM_WORDS      = 128,
  parameter int unsigned GNT_LATENCY    = 2,
  parameter int unsigned RVALID_LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
  localparam int unsigned MAX_LAT = (GNT_LATENCY > RVALID_LATENCY) ? GNT_LATENCY : RVALID_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int          NUM_BYTES = 4;

  localparam logic [CNT_W-1:0] GNT_LOAD = CNT_W'(GNT_LATENCY - 1);
  localparam logic [CNT_W-1:0] RSP_LOAD = CNT_W'(RVALID_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_WAIT  = 2'd1,
    RESP_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      resp_q, resp_d;

  logic [31:0]      mem [NUM_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic             access;
  logic             mem_we;
  logic             addr_unused;

  // Address bits outside the word index alias the array
  assign word_idx    = addr_i[IDX_W+1:2];
  assign addr_unused = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  // State register; the memory array below is deliberately left out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      resp_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
    end
  end

  // Memory write port, committed in the grant cycle
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (be_i[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = GNT_WAIT;
          cnt_d   = GNT_LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      GNT_WAIT: begin
        // cnt==0 is the cycle in which gnt_o is already high
        if (cnt_q == CNT_ZERO) begin
          state_d = RESP_WAIT;
          cnt_d   = RSP_LOAD;
        end else if (req_i) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      RESP_WAIT: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (req_i) begin
          state_d = GNT_WAIT;
          cnt_d   = GNT_LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are registered: pulses are scheduled one cycle ahead from the next state
  always_comb begin
    access   = (state_q == GNT_WAIT) && (cnt_q == CNT_ZERO);
    mem_we   = access && we_i;
    gnt_d    = (state_d == GNT_WAIT) && (cnt_d == CNT_ZERO);
    rvalid_d = (state_d == RESP_WAIT) && (cnt_d == CNT_ZERO);
    if (access) begin
      if (we_i) begin
        resp_d = 32'h0;
      end else begin
        resp_d = mem[word_idx];
      end
    end else begin
      resp_d = resp_q;
    end
    if (rvalid_d) begin
      rdata_d = resp_d;
    end else begin
      rdata_d = rdata_q;
    end
  end

  assign gnt_o    = gnt_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_ext_slow_memory.sv
// Scoreboard bench for ext_slow_memory: instance 0 uses the default latencies (2/3),
// instance 1 uses GNT_LATENCY=1, RVALID_LATENCY=1.
module tb_ext_slow_memory;

  localparam logic [31:0] BASE = 32'h2000_0000;

  typedef struct packed {
    logic        inst;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n  [2];
  logic        req    [2];
  logic        we     [2];
  logic [31:0] addr   [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        pending[2];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ext_slow_memory #(
      .NUM_WORDS      (128),
      .GNT_LATENCY    ((k == 0) ? 2 : 1),
      .RVALID_LATENCY ((k == 0) ? 3 : 1)
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n[k]),
      .req_i    (req[k]),
      .gnt_o    (gnt[k]),
      .addr_i   (addr[k]),
      .we_i     (we[k]),
      .be_i     (be[k]),
      .wdata_i  (wdata[k]),
      .rvalid_o (rvalid[k]),
      .rdata_o  (rdata[k])
    );
  end

  function automatic int glat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int rlat(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: pops the scoreboard on every response and polices gnt/rvalid ordering
  initial begin
    exp_t e;
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n[k]) begin
          pending[k] = 1'b0;
        end else begin
          if (rvalid[k]) begin
            check("rvalid_after_gnt", {31'h0, pending[k]}, 32'h1);
            pending[k] = 1'b0;
            check("rvalid_expected", {31'h0, (exp_q.size() != 0)}, 32'h1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("resp_instance", {31'h0, e.inst}, {31'h0, k[0]});
              check("rdata", rdata[k], e.data);
            end
          end
          if (gnt[k]) begin
            check("gnt_while_pending", {31'h0, pending[k]}, 32'h0);
            pending[k] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_gnt(input int k, input string name);
    int lat = 0;
    @(negedge clk);
    while (!gnt[k] && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check(name, lat, glat(k));
  endtask

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [31:0] exp_rd);
    int lat;
    exp_t e;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    e.inst = k[0];
    e.data = w ? 32'h0 : exp_rd;
    exp_q.push_back(e);
    wait_gnt(k, "gnt_latency");
    @(posedge clk); #1;
    req[k] = 1'b0; we[k] = ~w; addr[k] = 32'hFFFF_FFFC; be[k] = 4'hF; wdata[k] = 32'h5555_AAAA;
    lat = 1;
    @(negedge clk);
    while (!rvalid[k] && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("rvalid_latency", lat, rlat(k));
  endtask

  task automatic reset_mid_read(input int k, input logic [31:0] a);
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = 1'b0; addr[k] = a; be[k] = 4'h0;
    wait_gnt(k, "rst_gnt_latency");
    @(posedge clk); #1;
    req[k] = 1'b0;
    rst_n[k] = 1'b0;
    #1;
    check("rst_gnt", {31'h0, gnt[k]}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid[k]}, 32'h0);
    check("rst_rdata", rdata[k], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n[k] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic saw;
    logic [31:0] bb_addr [4];
    logic [31:0] bb_data [4];
    int prev;
    exp_t e;

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0;
      addr[k] = 32'h0; be[k] = 4'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_gnt", {31'h0, gnt[k]}, 32'h0);
      check("reset_rvalid", {31'h0, rvalid[k]}, 32'h0);
      check("reset_rdata", rdata[k], 32'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("idle_gnt", {31'h0, gnt[k]}, 32'h0);
        check("idle_rvalid", {31'h0, rvalid[k]}, 32'h0);
        check("idle_rdata", rdata[k], 32'h0);
      end
    end

    // Full write, read back, then partial write
    txn(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0);
    txn(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
    txn(0, 1'b1, BASE + 32'h10, 4'b0101, 32'h1122_3344, 32'h0);
    txn(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 32'hDE22_BE44);

    txn(0, 1'b1, BASE + 32'h00, 4'hF, 32'hA5A5_0001, 32'h0);
    txn(0, 1'b1, BASE + 32'h04, 4'hF, 32'h0000_1234, 32'h0);
    txn(0, 1'b1, BASE + 32'h08, 4'hF, 32'h8765_4321, 32'h0);

    // Four reads with req held high throughout
    bb_addr[0] = 32'h00; bb_data[0] = 32'hA5A5_0001;
    bb_addr[1] = 32'h04; bb_data[1] = 32'h0000_1234;
    bb_addr[2] = 32'h08; bb_data[2] = 32'h8765_4321;
    bb_addr[3] = 32'h10; bb_data[3] = 32'hDE22_BE44;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + bb_addr[0]; be[0] = 4'h0;
    e.inst = 1'b0; e.data = bb_data[0];
    exp_q.push_back(e);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        wait_gnt(0, "b2b_first_gnt");
      end else begin
        int lat = 0;
        @(negedge clk);
        while (!gnt[0] && lat < 40) begin
          lat++;
          @(negedge clk);
        end
        check("b2b_period", cyc - prev, 5);
      end
      prev = cyc;
      @(posedge clk); #1;
      if (i < 3) begin
        addr[0] = BASE + bb_addr[i+1];
        e.inst = 1'b0; e.data = bb_data[i+1];
        exp_q.push_back(e);
      end else begin
        req[0] = 1'b0;
      end
    end
    repeat (6) @(posedge clk);

    // Request withdrawn before grant: nothing may happen
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 32'h10; be[0] = 4'hF; wdata[0] = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    req[0] = 1'b0; we[0] = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw = saw | gnt[0] | rvalid[0];
    end
    check("abort_no_gnt_rvalid", {31'h0, saw}, 32'h0);
    txn(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 32'hDE22_BE44);

    // Upper address bits alias onto word 0
    txn(0, 1'b0, BASE + 32'h200, 4'h0, 32'h0, 32'hA5A5_0001);

    reset_mid_read(0, BASE + 32'h10);
    txn(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 32'hDE22_BE44);

    // Minimum-latency instance
    txn(1, 1'b1, BASE + 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0);
    txn(1, 1'b0, BASE + 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D);
    txn(1, 1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF, 32'h0);
    txn(1, 1'b0, BASE + 32'h220, 4'h0, 32'h0, 32'hCAFE_F00D);
    reset_mid_read(1, BASE + 32'h20);
    txn(1, 1'b0, BASE + 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
